// File: rtl/capture_ctrl.sv
// Acquisition sequencer for the logic-analyzer sample RAM: circular pre-fill, arm, trigger, post-trigger count.
// Optional build macro CAPTURE_AUTO_TRIG_EN adds a forced trigger after AUTO_CYC armed samples (auto_trig port).
module capture_ctrl #(
  parameter int ENTRIES  = 384,
  parameter int AW       = 9
`ifdef CAPTURE_AUTO_TRIG_EN
  ,
  parameter int AUTO_CYC = 1024
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          abort,
  input  logic          smpl_en,
  input  logic          trig_in,
  input  logic [AW-1:0] trig_pos,
  output logic          armed,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trig_addr,
  output logic          busy,
`ifdef CAPTURE_AUTO_TRIG_EN
  output logic          auto_trig,
`endif
  output logic          capture_done
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE
  } state_e;

  localparam logic [AW-1:0] LAST  = AW'(ENTRIES - 1);
  localparam logic [AW:0]   DEPTH = (AW+1)'(ENTRIES);

  state_e        state_q;
  logic          armed_q;
  logic [AW-1:0] waddr_q;
  logic [AW-1:0] trig_addr_q;
  logic [AW-1:0] pos_q;
  logic [AW:0]   pre_cnt_q;
  logic [AW-1:0] post_cnt_q;

  logic          capturing;
  logic          start;
  logic          trig_fire;
  logic [AW-1:0] waddr_inc;
  logic [AW-1:0] pos_clamp;
  logic [AW:0]   pre_need;
  logic [AW:0]   pre_inc;
  logic [AW-1:0] post_inc;

  always_comb begin
    capturing = (state_q == FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    start     = run && !abort && ((state_q == IDLE) || (state_q == DONE));
    waddr_inc = (waddr_q == LAST) ? '0 : waddr_q + AW'(1);
    pos_clamp = ({1'b0, trig_pos} >= DEPTH) ? LAST : trig_pos;
    pre_need  = DEPTH - {1'b0, pos_q};
    pre_inc   = pre_cnt_q + (AW+1)'(1);
    post_inc  = post_cnt_q + AW'(1);
  end

  // NOTE: we is a same-cycle decode of smpl_en so the RAM write lines up with the strobe;
  // registering it would shift every sample one cycle late.
  assign we           = smpl_en & capturing;
  assign busy         = capturing;
  assign capture_done = (state_q == DONE);
  assign armed        = armed_q;
  assign waddr        = waddr_q;
  assign trig_addr    = trig_addr_q;

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam logic [AW+1:0] AUTO_LIM = (AW+2)'(AUTO_CYC);

  logic [AW+1:0] auto_cnt_q;
  logic          auto_trig_q;
  logic          auto_hit;

  assign auto_hit  = (state_q == WAIT_TRIG) && (auto_cnt_q == AUTO_LIM);
  assign trig_fire = trig_in | auto_hit;
  assign auto_trig = auto_trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else if (abort || start) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else if (state_q == WAIT_TRIG) begin
      // A genuine trigger in the same cycle wins, so the sticky flag stays clear.
      if (trig_fire)  auto_trig_q <= ~trig_in;
      else if (we)    auto_cnt_q  <= auto_cnt_q + (AW+2)'(1);
    end
  end
`else
  assign trig_fire = trig_in;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every branch sees the
  // pre-edge values (e.g. waddr_q when latching trig_addr) regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      pos_q       <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
    end else begin
      if (we) waddr_q <= waddr_inc;

      if (abort) begin
        state_q <= IDLE;
        armed_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (run) begin
              state_q    <= FILL;
              pos_q      <= pos_clamp;
              pre_cnt_q  <= '0;
              post_cnt_q <= '0;
            end
          end
          FILL: begin
            if (we) begin
              pre_cnt_q <= pre_inc;
              if (pre_inc == pre_need) begin
                state_q <= WAIT_TRIG;
                armed_q <= 1'b1;
              end
            end
          end
          WAIT_TRIG: begin
            if (trig_fire) begin
              trig_addr_q <= we ? waddr_q : waddr_inc;
              armed_q     <= 1'b0;
              state_q     <= (pos_q == '0) ? DONE : POST;
            end
          end
          POST: begin
            if (we) begin
              post_cnt_q <= post_inc;
              if (post_inc == pos_q) state_q <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: stimulus pushes per-capture expectations, a negedge monitor scores each completion.
// Build with CAPTURE_AUTO_TRIG_EN defined to add the forced-trigger scenario (AUTO_CYC=16).
module tb_capture_ctrl;

  localparam int AW = 9;

  typedef struct {
    int pre;
    int taddr;
    int post;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          abort;
  logic          smpl_en;
  logic          trig_in;
  logic [AW-1:0] trig_pos;
  logic          armed;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          capture_done;
`ifdef CAPTURE_AUTO_TRIG_EN
  logic          auto_trig;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   strobe_mode = 0;   // 0: no strobes, 1: every cycle, 2: every 4th cycle
  exp_t exp_q[$];

`ifdef CAPTURE_AUTO_TRIG_EN
  capture_ctrl #(.ENTRIES(384), .AW(AW), .AUTO_CYC(16)) dut (
`else
  capture_ctrl #(.ENTRIES(384), .AW(AW)) dut (
`endif
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .abort        (abort),
    .smpl_en      (smpl_en),
    .trig_in      (trig_in),
    .trig_pos     (trig_pos),
    .armed        (armed),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .busy         (busy),
`ifdef CAPTURE_AUTO_TRIG_EN
    .auto_trig    (auto_trig),
`endif
    .capture_done (capture_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic push_exp(input int pre, input int taddr, input int post);
    exp_t e;
    e.pre   = pre;
    e.taddr = taddr;
    e.post  = post;
    exp_q.push_back(e);
  endtask

  task automatic wait_level(input string name, input bit want_done, input int budget);
    int n = 0;
    while ((want_done ? capture_done : armed) !== 1'b1) begin
      if (n == budget) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout after %0d cycles, got 0, required 1", name, budget);
        return;
      end
      tick();
      n++;
    end
  endtask

  // Strobe generator: updates smpl_en just after each rising edge.
  initial begin
    int phase = 0;
    smpl_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      case (strobe_mode)
        1:       smpl_en = 1'b1;
        2:       smpl_en = (phase == 0);
        default: smpl_en = 1'b0;
      endcase
    end
  end

  // NOTE: the monitor samples on the falling edge, half a cycle clear of both the DUT
  // update and the stimulus drive, so it always sees settled values.
  initial begin
    int   wr_cnt = 0;
    int   at_arm = 0;
    int   at_trig = 0;
    bit   prev_armed = 1'b0;
    bit   prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_armed = 1'b0;
        prev_done  = 1'b0;
        continue;
      end
      if (armed && !prev_armed) at_arm = wr_cnt;
      if (!armed && prev_armed) at_trig = wr_cnt;
      if (capture_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected_done: got done with trig_addr %0d, required no completion", trig_addr);
        end else begin
          e = exp_q.pop_front();
          check("sb_pre_writes", at_arm, e.pre);
          check("sb_trig_addr", trig_addr, e.taddr);
          check("sb_post_writes", wr_cnt - at_trig, e.post);
        end
      end
      if (run && !abort && !busy) wr_cnt = 0;
      else if (we)                wr_cnt++;
      prev_armed = armed;
      prev_done  = capture_done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    run      = 1'b0;
    abort    = 1'b0;
    trig_in  = 1'b0;
    trig_pos = '0;
    repeat (3) tick();
    check("rst_armed", armed, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", capture_done, 0);
    check("rst_waddr", waddr, 0);
    check("rst_trig_addr", trig_addr, 0);
    rst_n = 1'b1;
    tick();

    // A: continuous strobes, 100 post samples, trigger 50 cycles after arming.
    strobe_mode = 1;
    trig_pos    = 9'd100;
    push_exp(284, 334, 100);
    pulse_run();
    wait_level("A_armed", 1'b0, 400);
    repeat (50) tick();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    wait_level("A_done", 1'b1, 200);
    check("A_we_at_done", we, 0);
    check("A_busy_at_done", busy, 0);
    check("A_waddr", waddr, 51);
`ifdef CAPTURE_AUTO_TRIG_EN
    check("A_auto_trig", auto_trig, 0);
`endif
    repeat (3) tick();
    check("A_we_hold", we, 0);
    check("A_waddr_hold", waddr, 51);

    // B: sparse strobes, zero post samples, trig_in held through FILL, fires between strobes.
    strobe_mode = 2;
    trig_pos    = 9'd0;
    trig_in     = 1'b1;
    push_exp(384, 52, 0);
    pulse_run();
    wait_level("B_armed", 1'b0, 2000);
    tick();
    trig_in = 1'b0;
    check("B_done_next", capture_done, 1);
    check("B_trig_addr", trig_addr, 52);
    check("B_waddr", waddr, 51);

    // C: trig_pos beyond depth clamps to 383; later trig_pos change ignored; waddr wraps.
    strobe_mode = 1;
    trig_pos    = 9'd500;
    trig_in     = 1'b1;
    push_exp(1, 52, 383);
    pulse_run();
    trig_pos = 9'd5;
    wait_level("C_armed", 1'b0, 10);
    tick();
    trig_in = 1'b0;
    wait_level("C_done", 1'b1, 500);
    check("C_waddr", waddr, 52);

    // D: run while busy with a different trig_pos has no effect.
    trig_pos = 9'd10;
    push_exp(374, 42, 10);
    pulse_run();
    repeat (4) tick();
    trig_pos = 9'd200;
    run      = 1'b1;
    tick();
    run = 1'b0;
    wait_level("D_armed", 1'b0, 500);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    wait_level("D_done", 1'b1, 50);
    check("D_waddr", waddr, 53);

    // E: abort while armed returns to IDLE and keeps waddr.
    trig_pos = 9'd10;
    pulse_run();
    wait_level("E_armed", 1'b0, 500);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("E_armed", armed, 0);
    check("E_busy", busy, 0);
    check("E_done", capture_done, 0);
    check("E_waddr", waddr, 44);
    repeat (3) tick();
    check("E_waddr_hold", waddr, 44);
    check("E_we_idle", we, 0);

    // F: run and abort together stay in IDLE.
    run   = 1'b1;
    abort = 1'b1;
    tick();
    run   = 1'b0;
    abort = 1'b0;
    check("F_busy", busy, 0);
    tick();
    check("F_busy_hold", busy, 0);
    check("F_armed", armed, 0);
    check("F_waddr", waddr, 44);

    // G: reset pulse in the middle of POST.
    trig_pos = 9'd100;
    pulse_run();
    wait_level("G_armed", 1'b0, 400);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    repeat (20) tick();
    check("G_busy_post", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("G_armed", armed, 0);
    check("G_busy", busy, 0);
    check("G_done", capture_done, 0);
    check("G_waddr", waddr, 0);
    check("G_trig_addr", trig_addr, 0);
    tick();
    check("G_we_idle", we, 0);
    check("G_waddr_hold", waddr, 0);

`ifdef CAPTURE_AUTO_TRIG_EN
    // H: no trig_in; forced trigger after 16 armed writes.
    trig_pos = 9'd4;
    trig_in  = 1'b0;
    push_exp(380, 12, 4);
    pulse_run();
    wait_level("H_armed", 1'b0, 500);
    wait_level("H_done", 1'b1, 100);
    check("H_auto_trig", auto_trig, 1);
    check("H_waddr", waddr, 17);
`endif

    strobe_mode = 0;
    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
